channel_ctrl: RTL and testbench

Sequencer and write arbiter sitting in front of one GPS C/A tracking channel. Shares the channel's 3-bit address / 32-bit data register-write port between a host requester and a tracking-loop requester. Guarantees each write is a single-cycle strobe followed by an idle cycle, so the channel's phase-sync flags clear. Also sequences the channel's code-generator and NCO enables on start/stop.

---
 rtl/channel_ctrl.sv | 144 ++++++++++++++
 tb/tb_channel_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_ctrl.sv
// Write arbiter and enable sequencer for one GPS C/A tracking channel.
// Each register write is a one-cycle strobe followed by a 000 gap cycle so the phase-sync flags clear.
module channel_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        host_valid,
   input  logic [2:0]  host_addr,
   input  logic [31:0] host_data,
   output logic        host_ready,
   input  logic        loop_valid,
   input  logic [2:0]  loop_addr,
   input  logic [31:0] loop_data,
   output logic        loop_ready,
   input  logic        start,
   input  logic        stop,
   output logic [2:0]  ch_address,
   output logic [31:0] ch_data_value,
   output logic        ch_lo_nco_enable,
   output logic        ch_ca_nco_enable,
   output logic        ch_ca_gen_enable,
   output logic        running,
   output logic        addr_err
);

   typedef enum logic [1:0] {WIdle, WIssue, WGap} w_state_e;
   typedef enum logic [1:0] {COff, CArm, COn} c_state_e;

   w_state_e    w_state_q, w_state_d;
   c_state_e    c_state_q, c_state_d;
   logic        last_loop_q, last_loop_d;
   logic [2:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;
   logic        ca_gen_q, ca_gen_d;
   logic        nco_q, nco_d;
   logic        run_q, run_d;

   logic        grant_host, grant_loop, xfer, legal;
   logic [2:0]  sel_addr;
   logic [31:0] sel_data;

   // Write path: arbitration, capture and strobe/gap sequencing.
   always_comb begin
      grant_host  = 1'b0;
      grant_loop  = 1'b0;
      w_state_d   = w_state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      last_loop_d = last_loop_q;

      // Readies held low during reset since arbitration is combinational.
      if (w_state_q == WIdle && reset_n) begin
         if (host_valid && loop_valid) begin
            grant_host = last_loop_q;
         end else begin
            grant_host = host_valid;
         end
         grant_loop = loop_valid && !grant_host;
      end

      xfer     = grant_host || grant_loop;
      sel_addr = grant_host ? host_addr : loop_addr;
      sel_data = grant_host ? host_data : loop_data;
      if (grant_host) begin
         legal = (sel_addr >= 3'd1) && (sel_addr <= 3'd5);
      end else begin
         legal = (sel_addr == 3'd1) || (sel_addr == 3'd3);
      end
      err_d = xfer && !legal;

      if (xfer) begin
         last_loop_d = grant_loop;
      end

      unique case (w_state_q)
         WIdle: begin
            if (xfer && legal) begin
               w_state_d = WIssue;
               addr_d    = sel_addr;
               data_d    = sel_data;
            end
         end
         WIssue: begin
            w_state_d = WGap;
            addr_d    = 3'd0;
         end
         WGap:    w_state_d = WIdle;
         default: w_state_d = WIdle;
      endcase
   end

   // Control path: stop dominates, start only honoured from OFF.
   always_comb begin
      c_state_d = c_state_q;
      if (stop) begin
         c_state_d = COff;
      end else begin
         unique case (c_state_q)
            COff:    if (start) c_state_d = CArm;
            CArm:    c_state_d = COn;
            COn:     c_state_d = COn;
            default: c_state_d = COff;
         endcase
      end
      ca_gen_d = (c_state_d != COff);
      nco_d    = (c_state_d == COn);
      run_d    = (c_state_d == COn);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_state_q   <= WIdle;
         c_state_q   <= COff;
         last_loop_q <= 1'b1;
         addr_q      <= 3'd0;
         data_q      <= 32'd0;
         err_q       <= 1'b0;
         ca_gen_q    <= 1'b0;
         nco_q       <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         w_state_q   <= w_state_d;
         c_state_q   <= c_state_d;
         last_loop_q <= last_loop_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         err_q       <= err_d;
         ca_gen_q    <= ca_gen_d;
         nco_q       <= nco_d;
         run_q       <= run_d;
      end
   end

   assign host_ready       = grant_host;
   assign loop_ready       = grant_loop;
   assign ch_address       = addr_q;
   assign ch_data_value    = data_q;
   assign ch_ca_gen_enable = ca_gen_q;
   assign ch_lo_nco_enable = nco_q;
   assign ch_ca_nco_enable = nco_q;
   assign running          = run_q;
   assign addr_err         = err_q;

endmodule

// File: tb/tb_channel_ctrl.sv
// Bench for channel_ctrl: directed vector table, hand sequences for reset, and random traffic
// checked against a cycle-level behavioural model.
module tb_channel_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        host_valid, loop_valid, start, stop;
   logic [2:0]  host_addr, loop_addr;
   logic [31:0] host_data, loop_data;
   logic        host_ready, loop_ready;
   logic [2:0]  ch_address;
   logic [31:0] ch_data_value;
   logic        ch_lo_nco_enable, ch_ca_nco_enable, ch_ca_gen_enable, running, addr_err;

   int checks = 0;
   int errors = 0;

   channel_ctrl dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .host_valid       (host_valid),
      .host_addr        (host_addr),
      .host_data        (host_data),
      .host_ready       (host_ready),
      .loop_valid       (loop_valid),
      .loop_addr        (loop_addr),
      .loop_data        (loop_data),
      .loop_ready       (loop_ready),
      .start            (start),
      .stop             (stop),
      .ch_address       (ch_address),
      .ch_data_value    (ch_data_value),
      .ch_lo_nco_enable (ch_lo_nco_enable),
      .ch_ca_nco_enable (ch_ca_nco_enable),
      .ch_ca_gen_enable (ch_ca_gen_enable),
      .running          (running),
      .addr_err         (addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        hv;
      logic [2:0]  ha;
      logic [31:0] hd;
      logic        lv;
      logic [2:0]  la;
      logic [31:0] ld;
      logic        st;
      logic        sp;
      logic        hr;
      logic        lr;
      logic [2:0]  ea;
      logic [31:0] ed;
      logic [2:0]  en;   // {ca_gen, nco, running}
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic hv, logic [2:0] ha, logic [31:0] hd, logic lv,
                               logic [2:0] la, logic [31:0] ld, logic st, logic sp,
                               logic hr, logic lr, logic [2:0] ea, logic [31:0] ed,
                               logic [2:0] en, logic err);
      vec_t v;
      v.hv = hv; v.ha = ha; v.hd = hd; v.lv = lv; v.la = la; v.ld = ld; v.st = st; v.sp = sp;
      v.hr = hr; v.lr = lr; v.ea = ea; v.ed = ed; v.en = en; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic hv, input logic [2:0] ha, input logic [31:0] hd,
                        input logic lv, input logic [2:0] la, input logic [31:0] ld,
                        input logic st, input logic sp);
      host_valid = hv; host_addr = ha; host_data = hd;
      loop_valid = lv; loop_addr = la; loop_data = ld;
      start = st; stop = sp;
   endtask

   task automatic chk_outs(input string tag, input logic [2:0] ea, input logic [31:0] ed,
                           input logic [2:0] en, input logic err);
      chk({tag, " ch_address"}, {29'd0, ch_address}, {29'd0, ea});
      chk({tag, " ch_data_value"}, ch_data_value, ed);
      chk({tag, " enables"}, {29'd0, ch_ca_gen_enable, ch_lo_nco_enable, running},
          {29'd0, en});
      chk({tag, " ca_nco_enable"}, {31'd0, ch_ca_nco_enable}, {31'd0, en[1]});
      chk({tag, " addr_err"}, {31'd0, addr_err}, {31'd0, err});
   endtask

   // Behavioural model: remaining cycles of the strobe/gap window, last winner, control phase.
   int          m_busy;      // 2: strobe showing, 1: gap showing, 0: idle
   bit          m_last_host;
   int          m_ctrl;      // 0 off, 1 arming, 2 on
   logic [2:0]  m_addr;
   logic [31:0] m_data;
   logic        m_err;

   task automatic model_reset();
      m_busy = 0; m_last_host = 0; m_ctrl = 0; m_addr = 3'd0; m_data = 32'd0; m_err = 1'b0;
   endtask

   initial begin
      bit gh, gl, legal;
      logic [2:0]  a;
      logic [31:0] d;
      logic [2:0]  en;

      drive(1'b1, 3'd3, 32'h1, 1'b1, 3'd1, 32'h2, 1'b1, 1'b0);
      reset_n = 1'b0;
      #12;
      chk("reset host_ready", {31'd0, host_ready}, 32'd0);
      chk("reset loop_ready", {31'd0, loop_ready}, 32'd0);
      chk_outs("reset", 3'd0, 32'd0, 3'b000, 1'b0);
      drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // Directed vector table, applied from the first cycle after reset release.
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 0,            3'b000, 0));
      vecs.push_back(mk(1, 3, 32'h0FFF0000, 1, 1, 32'h77,   0, 0, 1, 0, 3, 32'h0FFF0000, 3'b000, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 32'h0FFF0000, 3'b000, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 32'h0FFF0000, 3'b000, 0));
      vecs.push_back(mk(0, 0, 0,            1, 2, 32'hDEAD, 0, 0, 0, 1, 0, 32'h0FFF0000, 3'b000, 1));
      vecs.push_back(mk(1, 2, 32'hAAAA5555, 0, 0, 0,        0, 0, 1, 0, 2, 32'hAAAA5555, 3'b000, 0));
      vecs.push_back(mk(1, 4, 32'h5555AAAA, 0, 0, 0,        0, 0, 0, 0, 0, 32'hAAAA5555, 3'b000, 0));
      vecs.push_back(mk(1, 4, 32'h5555AAAA, 0, 0, 0,        0, 0, 0, 0, 0, 32'hAAAA5555, 3'b000, 0));
      vecs.push_back(mk(1, 4, 32'h5555AAAA, 0, 0, 0,        0, 0, 1, 0, 4, 32'h5555AAAA, 3'b000, 0));
      vecs.push_back(mk(1, 1, 32'h1,        1, 3, 32'h2,    0, 0, 0, 0, 0, 32'h5555AAAA, 3'b000, 0));
      vecs.push_back(mk(1, 1, 32'h1,        1, 3, 32'h2,    0, 0, 0, 0, 0, 32'h5555AAAA, 3'b000, 0));
      vecs.push_back(mk(1, 1, 32'h1,        1, 3, 32'h2,    0, 0, 0, 1, 3, 32'h2,        3'b000, 0));
      vecs.push_back(mk(1, 1, 32'h1,        1, 3, 32'h2,    0, 0, 0, 0, 0, 32'h2,        3'b000, 0));
      vecs.push_back(mk(1, 1, 32'h1,        1, 3, 32'h2,    0, 0, 0, 0, 0, 32'h2,        3'b000, 0));
      vecs.push_back(mk(1, 1, 32'h1,        1, 3, 32'h2,    1, 0, 1, 0, 1, 32'h1,        3'b100, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 32'h1,        3'b111, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 1, 0, 0, 0, 32'h1,        3'b000, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 1, 0, 0, 0, 32'h1,        3'b000, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 32'h1,        3'b100, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 0, 0, 0, 0, 32'h1,        3'b111, 0));
      vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0, 32'h1,        3'b111, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].hv, vecs[i].ha, vecs[i].hd, vecs[i].lv, vecs[i].la, vecs[i].ld,
               vecs[i].st, vecs[i].sp);
         #2;
         chk($sformatf("vec%0d host_ready", i), {31'd0, host_ready}, {31'd0, vecs[i].hr});
         chk($sformatf("vec%0d loop_ready", i), {31'd0, loop_ready}, {31'd0, vecs[i].lr});
         @(posedge clk);
         #1;
         chk_outs($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ed, vecs[i].en, vecs[i].err);
         @(negedge clk);
      end

      // Reset during the strobe cycle aborts the write asynchronously.
      drive(1'b1, 3'd5, 32'hCAFEF00D, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      #2;
      chk("mid host_ready", {31'd0, host_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("mid strobe", {29'd0, ch_address}, 32'd5);
      #1;
      reset_n = 1'b0;
      #1;
      chk_outs("mid async", 3'd0, 32'd0, 3'b000, 1'b0);
      chk("mid reset host_ready", {31'd0, host_ready}, 32'd0);
      drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk_outs("post release", 3'd0, 32'd0, 3'b000, 1'b0);
      @(negedge clk);
      drive(1'b1, 3'd1, 32'h13579BDF, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         #2;
         chk($sformatf("rel c%0d host_ready", c), {31'd0, host_ready}, {31'd0, (c == 0 || c == 3)});
         @(posedge clk);
         #1;
         if (c < 3) begin
            chk_outs($sformatf("rel c%0d", c), (c == 0) ? 3'd1 : 3'd0, 32'h13579BDF, 3'b000, 1'b0);
         end
         @(negedge clk);
      end

      // Random traffic against the behavioural model.
      drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
         gh = 0;
         gl = 0;
         if (m_busy == 0) begin
            gh = host_valid && (!loop_valid || !m_last_host);
            gl = loop_valid && !gh;
         end
         #2;
         chk("rnd host_ready", {31'd0, host_ready}, {31'd0, gh});
         chk("rnd loop_ready", {31'd0, loop_ready}, {31'd0, gl});
         a = gh ? host_addr : loop_addr;
         d = gh ? host_data : loop_data;
         legal = gh ? (a >= 3'd1 && a <= 3'd5) : (a == 3'd1 || a == 3'd3);
         m_err = (gh || gl) && !legal;
         if (m_busy == 2) begin
            m_addr = 3'd0;
            m_busy = 1;
         end else if (m_busy == 1) begin
            m_busy = 0;
         end else if (gh || gl) begin
            m_last_host = gh;
            if (legal) begin
               m_addr = a;
               m_data = d;
               m_busy = 2;
            end
         end
         if (stop) m_ctrl = 0;
         else if (m_ctrl == 0 && start) m_ctrl = 1;
         else if (m_ctrl == 1) m_ctrl = 2;
         en = {m_ctrl != 0, m_ctrl == 2, m_ctrl == 2};
         @(posedge clk);
         #1;
         chk_outs("rnd", m_addr, m_data, en, m_err);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
